// File: rtl/mont_pkg.sv
// Shared Montgomery-datapath definitions: default widths and the exponent sequencer state encoding.
package mont_pkg;

  localparam int unsigned MONT_WIDTH     = 512;
  localparam int unsigned MONT_EXP_WIDTH = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_SQ,
    ST_WAIT_SQ,
    ST_REQ_MUL,
    ST_WAIT_MUL,
    ST_DONE
  } exp_state_e;

  // Bit index counter width; a 1-bit exponent still needs a 1-bit counter.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer; drives a Montgomery multiplier
// one request at a time and returns base^exp in Montgomery form.
module mont_exp_ctrl
  import mont_pkg::*;
#(
  parameter int unsigned WIDTH      = MONT_WIDTH,
  parameter int unsigned EXP_WIDTH  = MONT_EXP_WIDTH,
  parameter bit          CONST_TIME = 1'b1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [WIDTH-1:0]     base_mont_in,
  input  logic [WIDTH-1:0]     one_mont_in,
  input  logic [EXP_WIDTH-1:0] exp_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [WIDTH-1:0]     result_out,
  output logic                 mul_valid_out,
  input  logic                 mul_ready_in,
  output logic [WIDTH-1:0]     mul_a_out,
  output logic [WIDTH-1:0]     mul_b_out,
  input  logic                 mul_res_valid_in,
  input  logic [WIDTH-1:0]     mul_res_in
);

  localparam int unsigned IW = idx_bits(EXP_WIDTH);

  exp_state_e           state, state_nxt;
  logic [WIDTH-1:0]     acc, acc_nxt;
  logic [WIDTH-1:0]     base, base_nxt;
  logic [EXP_WIDTH-1:0] exp_r, exp_nxt;
  logic [IW-1:0]        idx, idx_nxt;
  logic [WIDTH-1:0]     result_nxt;
  logic                 exp_bit;
  logic                 advance;

  assign exp_bit  = exp_r[idx];
  assign busy_out = (state != ST_IDLE);
  assign done_out = (state == ST_DONE);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= ST_IDLE;
      acc        <= '0;
      base       <= '0;
      exp_r      <= '0;
      idx        <= '0;
      result_out <= '0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      base       <= base_nxt;
      exp_r      <= exp_nxt;
      idx        <= idx_nxt;
      result_out <= result_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    base_nxt      = base;
    exp_nxt       = exp_r;
    idx_nxt       = idx;
    result_nxt    = result_out;
    advance       = 1'b0;
    mul_valid_out = 1'b0;
    mul_a_out     = '0;
    mul_b_out     = '0;

    case (state)
      ST_IDLE: begin
        if (start_in) begin
          base_nxt  = base_mont_in;
          exp_nxt   = exp_in;
          acc_nxt   = one_mont_in;
          idx_nxt   = IW'(EXP_WIDTH - 1);
          state_nxt = ST_REQ_SQ;
        end
      end
      ST_REQ_SQ: begin
        mul_valid_out = 1'b1;
        mul_a_out     = acc;
        mul_b_out     = acc;
        if (mul_ready_in) state_nxt = ST_WAIT_SQ;
      end
      ST_WAIT_SQ: begin
        if (mul_res_valid_in) begin
          acc_nxt = mul_res_in;
          if (exp_bit || CONST_TIME) state_nxt = ST_REQ_MUL;
          else                       advance   = 1'b1;
        end
      end
      ST_REQ_MUL: begin
        mul_valid_out = 1'b1;
        mul_a_out     = acc;
        mul_b_out     = base;
        if (mul_ready_in) state_nxt = ST_WAIT_MUL;
      end
      ST_WAIT_MUL: begin
        // A zero exponent bit means this was the constant-time dummy; drop it.
        if (mul_res_valid_in) begin
          if (exp_bit) acc_nxt = mul_res_in;
          advance = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    // result_out is loaded on entry to DONE so it is already valid during the done pulse.
    if (advance) begin
      if (idx == '0) begin
        state_nxt  = ST_DONE;
        result_nxt = acc_nxt;
      end else begin
        idx_nxt   = idx - IW'(1);
        state_nxt = ST_REQ_SQ;
      end
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Scoreboard bench: two sequencers (constant-time and variable-time) against a
// behavioural Montgomery multiplier (N=13, R=256, R^-1 mod N = 3).
module tb_mont_exp_ctrl;

  localparam int W    = 8;
  localparam int EW   = 4;
  localparam int N    = 13;
  localparam int RINV = 3;

  typedef struct {
    int result;
    int cyc;   // expected start->done cycle number, 0 = not checked
    int hs;    // expected multiplier handshakes
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  base_m = '0;
  logic [W-1:0]  one_m = '0;
  logic [EW-1:0] exp_v = '0;

  logic          busy[2], done[2], mul_valid[2], mul_ready[2], res_valid[2];
  logic [W-1:0]  result[2], mul_a[2], mul_b[2], res[2];

  int   checks = 0;
  int   errors = 0;
  int   accept_delay = 0;
  int   res_delay = 0;
  bit   spur_en = 1'b0;
  int   hs[2];
  int   ncyc[2];
  exp_t sbq[2][$];

  always #5 clk = ~clk;

  mont_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW), .CONST_TIME(1'b1)) dut_ct (
    .clk_in(clk), .rst_in(rst_n), .start_in(start),
    .base_mont_in(base_m), .one_mont_in(one_m), .exp_in(exp_v),
    .busy_out(busy[0]), .done_out(done[0]), .result_out(result[0]),
    .mul_valid_out(mul_valid[0]), .mul_ready_in(mul_ready[0]),
    .mul_a_out(mul_a[0]), .mul_b_out(mul_b[0]),
    .mul_res_valid_in(res_valid[0]), .mul_res_in(res[0])
  );

  mont_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW), .CONST_TIME(1'b0)) dut_vt (
    .clk_in(clk), .rst_in(rst_n), .start_in(start),
    .base_mont_in(base_m), .one_mont_in(one_m), .exp_in(exp_v),
    .busy_out(busy[1]), .done_out(done[1]), .result_out(result[1]),
    .mul_valid_out(mul_valid[1]), .mul_ready_in(mul_ready[1]),
    .mul_a_out(mul_a[1]), .mul_b_out(mul_b[1]),
    .mul_res_valid_in(res_valid[1]), .mul_res_in(res[1])
  );

  function automatic logic [W-1:0] mont_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = (int'(a) * int'(b) * RINV) % N;
    return W'(p);
  endfunction

  function automatic exp_t mk(input int r, input int c, input int h);
    exp_t e;
    e.result = r;
    e.cyc    = c;
    e.hs     = h;
    return e;
  endfunction

  // Multiplier model: programmable accept stall and result delay, one request at a time.
  initial begin : responder
    int          wcnt[2], pcnt[2];
    logic [W-1:0] pend[2], ha[2], hb[2];
    bit          sp_done[2];
    for (int g = 0; g < 2; g++) begin
      mul_ready[g] = 1'b0; res_valid[g] = 1'b0; res[g] = '0;
      wcnt[g] = 0; pcnt[g] = 0; sp_done[g] = 1'b0; hs[g] = 0;
      pend[g] = '0; ha[g] = '0; hb[g] = '0;
    end
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        res_valid[g] = 1'b0;
        if (start && !busy[g]) hs[g] = 0;
        if (!spur_en) sp_done[g] = 1'b0;
        if (pcnt[g] > 0) begin
          pcnt[g]--;
          if (pcnt[g] == 0) begin
            res_valid[g] = 1'b1;
            res[g]       = pend[g];
          end
        end
        if (mul_valid[g]) begin
          if (wcnt[g] == 0) begin
            ha[g] = mul_a[g];
            hb[g] = mul_b[g];
          end else begin
            checks++;
            if (mul_a[g] !== ha[g] || mul_b[g] !== hb[g]) begin
              errors++;
              $display("FAIL stall_hold dut%0d: a=%0d b=%0d, required a=%0d b=%0d",
                       g, mul_a[g], mul_b[g], ha[g], hb[g]);
            end
          end
          if (wcnt[g] < accept_delay) begin
            mul_ready[g] = 1'b0;
            wcnt[g]++;
            if (spur_en && !sp_done[g] && pcnt[g] == 0) begin
              res_valid[g] = 1'b1;
              res[g]       = 8'hAB;
              sp_done[g]   = 1'b1;
            end
          end else begin
            mul_ready[g] = 1'b1;
          end
        end else begin
          if (wcnt[g] > 0) begin
            checks++;
            errors++;
            $display("FAIL valid_hold dut%0d: valid=0 while stalled, required 1", g);
          end
          mul_ready[g] = 1'b0;
          wcnt[g]      = 0;
        end
        if (mul_valid[g] && mul_ready[g]) begin
          hs[g]++;
          pend[g] = mont_mul(mul_a[g], mul_b[g]);
          pcnt[g] = res_delay + 1;
          wcnt[g] = 0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every done pulse.
  initial begin : monitor
    bit   prev_done[2];
    exp_t e;
    prev_done[0] = 1'b0;
    prev_done[1] = 1'b0;
    ncyc[0] = 0;
    ncyc[1] = 0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (start && !busy[g]) ncyc[g] = 1;
        else                   ncyc[g]++;
        if (prev_done[g]) begin
          checks++;
          if (done[g] !== 1'b0) begin
            errors++;
            $display("FAIL done_width dut%0d: done high 2 cycles, required 1", g);
          end
        end
        prev_done[g] = done[g];
        if (done[g] === 1'b1) begin
          checks++;
          if (sbq[g].size() == 0) begin
            errors++;
            $display("FAIL unexpected_done dut%0d: result=%0d, required no done", g, result[g]);
          end else begin
            e = sbq[g].pop_front();
            if (int'(result[g]) != e.result) begin
              errors++;
              $display("FAIL result dut%0d: got %0d, required %0d", g, result[g], e.result);
            end
            checks++;
            if (hs[g] != e.hs) begin
              errors++;
              $display("FAIL handshakes dut%0d: got %0d, required %0d", g, hs[g], e.hs);
            end
            if (e.cyc > 0) begin
              checks++;
              if (ncyc[g] != e.cyc) begin
                errors++;
                $display("FAIL latency dut%0d: done at cycle %0d, required %0d", g, ncyc[g], e.cyc);
              end
            end
          end
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run(input logic [EW-1:0] e, input logic [W-1:0] b, input exp_t e0, input exp_t e1);
    base_m = b;
    one_m  = 8'd9;
    exp_v  = e;
    sbq[0].push_back(e0);
    sbq[1].push_back(e1);
    pulse_start();
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while ((sbq[0].size() != 0 || sbq[1].size() != 0 || busy[0] || busy[1]) && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (t >= budget) begin
      errors++;
      $display("FAIL timeout: %0d cycles, required < %0d", t, budget);
      sbq[0].delete();
      sbq[1].delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (busy[g] !== 1'b0 || done[g] !== 1'b0 || mul_valid[g] !== 1'b0 ||
          result[g] !== '0 || mul_a[g] !== '0 || mul_b[g] !== '0) begin
        errors++;
        $display("FAIL %s dut%0d: busy=%b done=%b valid=%b result=%0d a=%0d b=%0d, required all 0",
                 tag, g, busy[g], done[g], mul_valid[g], result[g], mul_a[g], mul_b[g]);
      end
    end
  endtask

  initial begin : stimulus
    int t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // exp=5, base mont 5: result mont(6)=2
    run(4'd5, 8'd5, mk(2, 18, 8), mk(2, 14, 6));
    wait_done(200);
    // exp=0: squares of the Montgomery one only
    run(4'd0, 8'd5, mk(9, 18, 8), mk(9, 10, 4));
    wait_done(200);
    // exp=15: 2^15 mod 13 = 8 -> mont 7
    run(4'hF, 8'd5, mk(7, 18, 8), mk(7, 18, 8));
    wait_done(200);
    // exp=8 (MSB only): 2^8 mod 13 = 9 -> mont 3
    run(4'd8, 8'd5, mk(3, 18, 8), mk(3, 12, 5));
    wait_done(200);
    // exp=1 (LSB only): mont(2) = 5
    run(4'd1, 8'd5, mk(5, 18, 8), mk(5, 12, 5));
    wait_done(200);

    // backpressure and slow products
    accept_delay = 5;
    res_delay    = 3;
    run(4'd5, 8'd5, mk(2, 0, 8), mk(2, 0, 6));
    wait_done(400);

    // mid-run start with different operands and a spurious product in REQ_SQ
    accept_delay = 2;
    res_delay    = 0;
    spur_en      = 1'b1;
    run(4'd5, 8'd5, mk(2, 0, 8), mk(2, 0, 6));
    repeat (6) @(posedge clk);
    #1;
    exp_v  = 4'hF;
    base_m = 8'd7;
    one_m  = 8'd1;
    pulse_start();
    wait_done(400);
    spur_en      = 1'b0;
    accept_delay = 0;

    // reset while the constant-time instance waits for its first multiply product
    res_delay = 4;
    base_m = 8'd5;
    one_m  = 8'd9;
    exp_v  = 4'd5;
    pulse_start();
    t = 0;
    while (hs[0] < 2 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (t >= 100) begin
      errors++;
      $display("FAIL reach_wait_mul: handshakes=%0d, required 2", hs[0]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    res_delay = 0;
    repeat (12) @(posedge clk);
    #1;
    check_zero("late_product");
    run(4'd5, 8'd5, mk(2, 18, 8), mk(2, 14, 6));
    wait_done(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
